// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request, shifts one byte on device clock edges, checks ACK.
// Optional `PS2_TX_RESEND_EN`: one silent retry after a NACK or timeout.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg_o,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [7:0]       byte_q, byte_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;
`ifdef PS2_TX_RESEND_EN
    logic             retry_q, retry_d;
`endif

    logic       clk_s, data_s, fall, parity, fail, do_retry;
    logic [1:0] fail_code;

    // Valid/ready: a byte is taken on any clk edge where tx_valid && tx_ready; tx_ready
    // stays low through the done/err pulse so a request in that cycle is not taken.
    assign tx_ready    = (state_q == S_IDLE) && !done_q && !err_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign err_code    = code_q;
    assign state_dbg_o = state_q;

    assign ps2_clk  = clk_low_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_low_q ? 1'b0 : 1'bz;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q && !clk_s;
    assign parity = ~^byte_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        n_d        = n_q;
        byte_d     = byte_q;
        data_low_d = data_low_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        fail       = 1'b0;
        fail_code  = 2'b00;
        do_retry   = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid && tx_ready) begin
                    byte_d  = tx_data;
                    code_d  = 2'b00;
                    state_d = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_d = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d    = S_REQ;
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_SEND;
                cnt_d   = '0;
                n_d     = 4'd0;
            end
            S_SEND: begin
                // A falling edge always beats a coincident timeout.
                if (fall) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q < 4'd8) begin
                        data_low_d = ~byte_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        data_low_d = ~parity;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = S_ACK;
                    end
                end else if (cnt_q == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (!data_s) begin
                        state_d = S_RELEASE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end
                end else if (cnt_q == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            S_RELEASE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PS2_TX_RESEND_EN
        do_retry = fail && !retry_q && (fail_code != 2'b11);
        if (do_retry) retry_d = 1'b1;
`endif
        if (fail) begin
            cnt_d      = '0;
            n_d        = 4'd0;
            data_low_d = 1'b0;
            if (do_retry) begin
                state_d = S_INHIBIT;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = fail_code;
            end
        end

        if (state_d != S_REQ && state_d != S_SEND) data_low_d = 1'b0;
        clk_low_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= 4'd0;
            byte_q      <= 8'h00;
            clk_low_q   <= 1'b0;
            data_low_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            byte_q      <= byte_d;
            clk_low_q   <= clk_low_d;
            data_low_q  <= data_low_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_s;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the same open-drain PS2 clock/data pair that the keyboard receive path listens on.
- Performs the request-to-send inhibit sequence, then shifts the frame out on device-generated clock edges, then checks the device ACK.
- Reports the outcome to the requesting logic through a valid/ready handshake and a done/error pulse.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles that ps2_clk is held low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum clk cycles between consecutive expected line events before the transfer aborts (15 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  command byte; captured on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready at a clk edge.
- busy  out  1  high from the accept edge until return to IDLE.
- tx_done  out  1  1-cycle pulse on successful, ACKed transfer.
- tx_err  out  1  1-cycle pulse on failed transfer; mutually exclusive with tx_done.
- err_code  out  2  valid with tx_err and held until the next accept: 01 NACK, 10 timeout, 11 lines not released.
- ps2_clk  inout  1  open-drain; drives 0 or z only.
- ps2_data  inout  1  open-drain; drives 0 or z only.

Behaviour:
- Reset (asynchronous) values:
  - Both lines released (z) immediately, including mid-frame.
  - State IDLE; tx_ready=1; busy=0; tx_done=0; tx_err=0; err_code=00; internal counters 0.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchronizer. A falling edge is synced clk 1 -> 0. All line sampling uses the synced values.
- Parity: odd parity, par = ~^byte.
- FSM:
  - IDLE: accept the byte, go to INHIBIT.
  - INHIBIT: drive ps2_clk low for exactly INHIBIT_CYCLES cycles; data released.
  - REQ: 1 cycle with clk low and data low (start bit).
  - SEND: release clk, keep data low. Count falling edges n:
    - n=1..8: drive data = byte[n-1], LSB first.
    - n=9: drive parity.
    - n=10: release data (stop bit).
    - Data changes in the clk cycle after the detected edge.
  - ACK: wait for falling edge 11, then sample data. data=0 is an ACK and goes to RELEASE; data=1 is a NACK and ends with err_code 01.
  - RELEASE: wait until both synced lines are high, then pulse tx_done and return to IDLE.
- Timeout:
  - The counter clears on entering SEND and on every detected falling edge or exit condition.
  - Reaching TIMEOUT_CYCLES in SEND or ACK fails with err_code 10.
  - Reaching TIMEOUT_CYCLES in RELEASE fails with err_code 11.
- Failure handling: release both lines the same cycle the failure is detected, pulse tx_err, return to IDLE.
- tx_ready is low the cycle after accept and stays low until the cycle after the tx_done or tx_err pulse.
- tx_valid while busy is ignored; no queueing.
- Simultaneous events:
  - A falling edge and a timeout in the same cycle: the edge wins.
  - tx_valid in the same cycle as a done/err pulse: not accepted, because tx_ready is still low.
- The block never drives a line high. Glitches on ps2_clk shorter than 2 clk cycles are not filtered; this is accepted.

Optional Feature:
- PS2_TX_RESEND_EN defined: on the first NACK or timeout (codes 01 or 10), the block silently restarts from INHIBIT with the same byte, once. tx_err fires only if the retry also fails. No tx_done/tx_err pulse between attempts, and busy stays high throughout. Code 11 is never retried.
- Undefined: the first failure pulses tx_err immediately.

Test Plan:
- Send 0xED; device model clocks 11 edges with ACK low. Data bits seen at edges 1..8 must be 1,0,1,1,0,1,1,1, parity 1, stop released. Then tx_done pulse, err 0, tx_ready back to 1.
- Send 0x01, 0x00 and 0xFF. Sampled parity must be 0, 1 and 1 respectively. Each ends with tx_done.
- Device holds data high at edge 11 (NACK). tx_err pulses with err_code 01, both lines z in the same cycle, no tx_done. With PS2_TX_RESEND_EN, a second INHIBIT starts first and err fires only after a second NACK.
- TIMEOUT_CYCLES=50; device never clocks. tx_err with err_code 10 exactly 50 cycles after SEND entry; lines released.
- INHIBIT_CYCLES=20: ps2_clk is low for exactly 21 cycles (20 INHIBIT + 1 REQ), and data falls only in the REQ cycle. Pulse tx_valid with new data during the transfer: it is ignored, and only the first byte appears on the wire.
- Assert rst at edge 5 of a frame. Both lines are z asynchronously, and tx_ready=1 after rst drops. A following 0xF4 send completes normally.
